// File: rtl/fp_normalizer_pkg.sv
// Shared definitions for the mini-float normalizer: default widths, exponent
// constants, the packed result word and a generic leading-zero count helper.
package fp_normalizer_pkg;

  localparam int FP_MANT_W = 4;
  localparam int FP_EXP_W  = 3;
  localparam int FP_SUM_W  = FP_MANT_W + 2;

  localparam logic [FP_EXP_W-1:0] EXP_MAX  = {FP_EXP_W{1'b1}};
  localparam logic [FP_EXP_W-1:0] ZERO_EXP = {FP_EXP_W{1'b0}};

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_t;

  // Leading zeros of vec[width-1:0]; returns width when the field is all zero.
  function automatic int lzc(input logic [31:0] vec, input int width);
    int   cnt;
    logic found;
    cnt   = 0;
    found = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      if (vec[i] == 1'b1) begin
        found = 1'b1;
      end else if (!found) begin
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fp_normalizer_if.sv
// Stream interface of the normalizer: raw-sum input side and normalized output
// side, each with its own valid/ready pair.
interface fp_normalizer_if
  import fp_normalizer_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W,
  parameter int SUM_W  = MANT_W + 2
);

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [SUM_W-1:0]  in_sum;

  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_ovf;
  logic              out_uf;

  // Producer of raw sums and consumer of normalized results.
  modport master (
    output in_valid, in_sign, in_exp, in_sum, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_uf
  );

  // The normalizer itself.
  modport slave (
    input  in_valid, in_sign, in_exp, in_sum, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_uf
  );

endinterface

// File: rtl/fp_normalizer_leading_zero_counter.sv
// Combinational leading-zero counter over a WIDTH-bit vector (WIDTH <= 32).
// An all-zero vector yields WIDTH.
module fp_normalizer_leading_zero_counter
  import fp_normalizer_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_count
);

  logic [31:0] w_vec;

  assign w_vec = 32'(i_vec);

  // Count from the MSB down to the first set bit.
  always_comb begin
    o_count = CNT_W'(lzc(w_vec, WIDTH));
  end

endmodule

// File: rtl/fp_normalizer.sv
// Post-add normalization stage of the mini-float adder.
// Stage 1 captures the raw sum with carry/zero flags and its leading-zero count;
// stage 2 shifts the significand, adjusts the exponent and registers the result.
// Optional macro FP_NORM_SAT_EN: when defined, exponent overflow saturates to the
// largest finite value; otherwise it produces the infinity encoding (mant=0).
module fp_normalizer
  import fp_normalizer_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W,
  parameter int SUM_W  = MANT_W + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_normalizer_if.slave  bus
);

  localparam int              LZ_W      = $clog2(SUM_W);
  localparam logic [EXP_W-1:0] L_EXP_MAX = {EXP_W{1'b1}};

  // Handshake
  logic w_s2_free;
  logic w_in_ready;
  logic w_in_fire;

  // Stage 1 registers
  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [SUM_W-2:0]  r_s1_low;
  logic              r_s1_carry;
  logic              r_s1_zero;
  logic [LZ_W-1:0]   r_s1_lz;

  // Stage 2 (output) registers
  logic              r_out_valid;
  logic              r_out_sign;
  logic [EXP_W-1:0]  r_out_exp;
  logic [MANT_W-1:0] r_out_mant;
  logic              r_out_ovf;
  logic              r_out_uf;

  // Stage 2 next-state values
  logic [LZ_W-1:0]   w_lz;
  logic [EXP_W:0]    w_exp_ext;
  logic [EXP_W:0]    w_lz_ext;
  logic [EXP_W:0]    w_exp_inc;
  logic [EXP_W:0]    w_exp_dec;
  logic [SUM_W-2:0]  w_shifted;
  logic              w_n_sign;
  logic [EXP_W-1:0]  w_n_exp;
  logic [MANT_W-1:0] w_n_mant;
  logic              w_n_ovf;
  logic              w_n_uf;

  assign w_s2_free  = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_free;
  assign w_in_fire  = bus.in_valid && w_in_ready;

  fp_normalizer_leading_zero_counter #(
    .WIDTH (SUM_W - 1),
    .CNT_W (LZ_W)
  ) u_lzc (
    .i_vec   (bus.in_sum[SUM_W-2:0]),
    .o_count (w_lz)
  );

  // Stage 1: capture the incoming word and its classification flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= {EXP_W{1'b0}};
      r_s1_low   <= {(SUM_W-1){1'b0}};
      r_s1_carry <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_lz    <= {LZ_W{1'b0}};
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_sign  <= bus.in_sign;
      r_s1_exp   <= bus.in_exp;
      r_s1_low   <= bus.in_sum[SUM_W-2:0];
      r_s1_carry <= bus.in_sum[SUM_W-1];
      r_s1_zero  <= (bus.in_sum == {SUM_W{1'b0}});
      r_s1_lz    <= w_lz;
    end else if (w_s2_free) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Exponent math is one bit wider so overflow/underflow never wraps.
  assign w_exp_ext = {1'b0, r_s1_exp};
  assign w_lz_ext  = (EXP_W+1)'(r_s1_lz);
  assign w_exp_inc = w_exp_ext + {{EXP_W{1'b0}}, 1'b1};
  assign w_exp_dec = w_exp_ext - w_lz_ext;
  assign w_shifted = r_s1_low << r_s1_lz;

  // Stage 2 datapath: zero, then carry right-shift, then leading-zero left-shift.
  always_comb begin
    w_n_sign = 1'b0;
    w_n_exp  = {EXP_W{1'b0}};
    w_n_mant = {MANT_W{1'b0}};
    w_n_ovf  = 1'b0;
    w_n_uf   = 1'b0;
    if (r_s1_zero) begin
      w_n_sign = 1'b0;
    end else if (r_s1_carry) begin
      w_n_sign = r_s1_sign;
      if (w_exp_inc[EXP_W]) begin
        w_n_ovf = 1'b1;
        w_n_exp = L_EXP_MAX;
`ifdef FP_NORM_SAT_EN
        w_n_mant = {MANT_W{1'b1}};
`else
        w_n_mant = {MANT_W{1'b0}};
`endif
      end else begin
        w_n_exp  = w_exp_inc[EXP_W-1:0];
        w_n_mant = r_s1_low[SUM_W-2:1];
      end
    end else begin
      if (w_exp_ext <= w_lz_ext) begin
        // Would need an exponent of zero or below: flush to positive zero.
        w_n_uf = 1'b1;
      end else begin
        w_n_sign = r_s1_sign;
        w_n_exp  = w_exp_dec[EXP_W-1:0];
        w_n_mant = w_shifted[MANT_W-1:0];
      end
    end
  end

  // Stage 2: register the normalized word; hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= {EXP_W{1'b0}};
      r_out_mant  <= {MANT_W{1'b0}};
      r_out_ovf   <= 1'b0;
      r_out_uf    <= 1'b0;
    end else if (w_s2_free) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sign <= w_n_sign;
        r_out_exp  <= w_n_exp;
        r_out_mant <= w_n_mant;
        r_out_ovf  <= w_n_ovf;
        r_out_uf   <= w_n_uf;
      end else begin
        r_out_sign <= r_out_sign;
        r_out_exp  <= r_out_exp;
        r_out_mant <= r_out_mant;
        r_out_ovf  <= r_out_ovf;
        r_out_uf   <= r_out_uf;
      end
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sign  = r_out_sign;
  assign bus.out_exp   = r_out_exp;
  assign bus.out_mant  = r_out_mant;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_uf    = r_out_uf;

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer with directed, hand-computed vectors.
module tb_fp_normalizer;
  import fp_normalizer_pkg::*;

  localparam int MW = FP_MANT_W;
  localparam int EW = FP_EXP_W;
  localparam int SW = FP_SUM_W;

`ifdef FP_NORM_SAT_EN
  localparam logic [MW-1:0] OVF_M = 4'b1111;
`else
  localparam logic [MW-1:0] OVF_M = 4'b0000;
`endif

  typedef struct packed {
    fp_t  word;
    logic ovf;
    logic uf;
  } res_t;

  typedef struct {
    res_t res;
    int   cyc;
    bit   chk_lat;
    int   id;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_normalizer_if #(.MANT_W(MW), .EXP_W(EW), .SUM_W(SW)) bus ();

  fp_normalizer #(.MANT_W(MW), .EXP_W(EW), .SUM_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(input logic s, input logic [EW-1:0] e,
                              input logic [MW-1:0] m, input logic o, input logic u);
    res_t r;
    r.word.sign = s;
    r.word.exp  = e;
    r.word.mant = m;
    r.ovf       = o;
    r.uf        = u;
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Present one word and hold it until accepted; expected result goes to the queue.
  task automatic send(input logic s, input logic [EW-1:0] e, input logic [SW-1:0] sum,
                      input res_t r, input bit lat, input int id);
    bit acc   = 1'b0;
    int waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_sum   = sum;
    while (!acc && waitc < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) q.push_back('{r, cyc, lat, id});
      @(posedge clk);
      #1;
      waitc++;
    end
    bus.in_valid = 1'b0;
    if (acc) n_acc++;
    else check($sformatf("send_timeout id=%0d", id), 0, 1);
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1;
    check(name, q.size(), 0);
  endtask

  initial begin
    int start_acc;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 3'd0;
    bus.in_sum    = 6'd0;
    bus.out_ready = 1'b0;

    // Monitor: pop and compare whenever a result is handed over.
    fork
      forever begin
        res_t got;
        ent_t e;
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
          got = mk(bus.out_sign, bus.out_exp, bus.out_mant, bus.out_ovf, bus.out_uf);
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %b, expected no output", got);
          end else begin
            e = q.pop_front();
            if (got !== e.res) begin
              n_fail++;
              $display("FAIL result id=%0d: got s=%b e=%0d m=%b ovf=%b uf=%b, expected s=%b e=%0d m=%b ovf=%b uf=%b",
                       e.id, got.word.sign, got.word.exp, got.word.mant, got.ovf, got.uf,
                       e.res.word.sign, e.res.word.exp, e.res.word.mant, e.res.ovf, e.res.uf);
            end
            if (e.chk_lat) check("latency", cyc - e.cyc, 2);
          end
        end
      end
    join_none

    // Reset state
    #12;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sign",  int'(bus.out_sign), 0);
    check("rst_out_exp",   int'(bus.out_exp), 0);
    check("rst_out_mant",  int'(bus.out_mant), 0);
    check("rst_out_ovf",   int'(bus.out_ovf), 0);
    check("rst_out_uf",    int'(bus.out_uf), 0);
    check("rst_in_ready",  int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Directed vectors, streamed back to back
    send(1'b0, 3'd3, 6'b10_1010, mk(1'b0, 3'd4, 4'b0101, 1'b0, 1'b0), 1'b1, 1);
    send(1'b0, 3'd5, 6'b00_0110, mk(1'b0, 3'd3, 4'b1000, 1'b0, 1'b0), 1'b0, 2);
    send(1'b1, 3'd5, 6'b00_0110, mk(1'b1, 3'd3, 4'b1000, 1'b0, 1'b0), 1'b0, 3);
    send(1'b1, 3'd6, 6'b00_0000, mk(1'b0, 3'd0, 4'b0000, 1'b0, 1'b0), 1'b0, 4);
    send(1'b0, 3'd2, 6'b00_0011, mk(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1), 1'b0, 5);
    send(1'b0, 3'd7, 6'b11_0000, mk(1'b0, 3'd7, OVF_M,   1'b1, 1'b0), 1'b0, 6);
    send(1'b1, 3'd7, 6'b10_0001, mk(1'b1, 3'd7, OVF_M,   1'b1, 1'b0), 1'b0, 7);
    send(1'b0, 3'd6, 6'b11_1111, mk(1'b0, 3'd7, 4'b1111, 1'b0, 1'b0), 1'b0, 8);
    send(1'b0, 3'd5, 6'b01_1011, mk(1'b0, 3'd5, 4'b1011, 1'b0, 1'b0), 1'b0, 9);
    send(1'b0, 3'd5, 6'b00_0001, mk(1'b0, 3'd1, 4'b0000, 1'b0, 1'b0), 1'b0, 10);
    send(1'b1, 3'd4, 6'b00_0001, mk(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1), 1'b0, 11);
    send(1'b0, 3'd1, 6'b10_0000, mk(1'b0, 3'd2, 4'b0000, 1'b0, 1'b0), 1'b0, 12);
    send(1'b0, 3'd1, 6'b01_0000, mk(1'b0, 3'd1, 4'b0000, 1'b0, 1'b0), 1'b0, 13);
    send(1'b0, 3'd0, 6'b01_0000, mk(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1), 1'b0, 14);
    drain("drain_directed");

    // Backpressure: two words fill the pipe, then the input stalls
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    start_acc = n_acc;
    fork
      begin
        send(1'b0, 3'd5, 6'b00_0110, mk(1'b0, 3'd3, 4'b1000, 1'b0, 1'b0), 1'b0, 21);
        send(1'b0, 3'd5, 6'b01_1011, mk(1'b0, 3'd5, 4'b1011, 1'b0, 1'b0), 1'b0, 22);
        send(1'b0, 3'd5, 6'b00_0001, mk(1'b0, 3'd1, 4'b0000, 1'b0, 1'b0), 1'b0, 23);
        send(1'b0, 3'd1, 6'b10_0000, mk(1'b0, 3'd2, 4'b0000, 1'b0, 1'b0), 1'b0, 24);
      end
      begin
        repeat (4) @(negedge clk);
        check("stall_accepted", n_acc - start_acc, 2);
        check("stall_in_ready", int'(bus.in_ready), 0);
        check("stall_out_valid", int'(bus.out_valid), 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check($sformatf("burst_valid_%0d", i), int'(bus.out_valid), 1);
        end
      end
    join
    drain("drain_burst");

    // Reset with both stages full discards everything in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(1'b0, 3'd3, 6'b10_1010, mk(1'b0, 3'd4, 4'b0101, 1'b0, 1'b0), 1'b0, 31);
    send(1'b0, 3'd5, 6'b00_0110, mk(1'b0, 3'd3, 4'b1000, 1'b0, 1'b0), 1'b0, 32);
    check("full_out_valid", int'(bus.out_valid), 1);
    check("full_in_ready", int'(bus.in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_exp", int'(bus.out_exp), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_ghost", int'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
